// File: rtl/bcd_cnt_pkg.sv
// Shared types and constants for the BCD modulo counter.
// bin2bcd turns the binary terminal value into packed BCD when the design is elaborated.
package bcd_cnt_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX  = 4'd9;
   localparam bcd_digit_t BCD_ZERO = 4'd0;
   localparam int         MAX_DIG  = 6;

   function automatic logic [4*MAX_DIG-1:0] bin2bcd(input int unsigned value);
      logic [4*MAX_DIG-1:0] result;
      int unsigned          rest;
      result = '0;
      rest   = value;
      for (int i = 0; i < MAX_DIG; i++) begin
         result[4*i +: 4] = 4'(rest % 10);
         rest             = rest / 10;
      end
      return result;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade cell of the BCD counter: holds one digit and passes carry/borrow to the next cell.
// The dir_i port and the decrement path exist only when BCD_CNT_UPDOWN_EN is defined.
module bcd_digit
   import bcd_cnt_pkg::*;
(
   input  logic       clk,
   input  logic       rs_n,
   input  logic       step_i,
`ifdef BCD_CNT_UPDOWN_EN
   input  logic       dir_i,
`endif
   input  logic       force_zero_i,
   input  logic       force_load_i,
   input  logic [3:0] load_val_i,
   output logic [3:0] digit_o,
   output logic       step_o
);

   bcd_digit_t digit_q, digit_d;
   logic       atLimit;

`ifdef BCD_CNT_UPDOWN_EN
   assign atLimit = dir_i ? (digit_q == BCD_MAX) : (digit_q == BCD_ZERO);
`else
   assign atLimit = (digit_q == BCD_MAX);
`endif

   assign step_o  = step_i & atLimit;
   assign digit_o = digit_q;

   always_comb begin
      digit_d = digit_q;
      if (force_zero_i) begin
         digit_d = BCD_ZERO;
      end else if (force_load_i) begin
         digit_d = load_val_i;
      end else if (step_i) begin
`ifdef BCD_CNT_UPDOWN_EN
         if (!dir_i)
            digit_d = (digit_q == BCD_ZERO) ? BCD_MAX : digit_q - 4'd1;
         else
`endif
            digit_d = (digit_q == BCD_MAX) ? BCD_ZERO : digit_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rs_n) begin
      if (!rs_n) digit_q <= BCD_ZERO;
      else       digit_q <= digit_d;
   end

endmodule

// File: rtl/bcd_mod_counter.sv
// Multi-digit BCD modulo-MODULUS counter with clear, checked load and cascadable terminal count.
// Define BCD_CNT_UPDOWN_EN to enable down counting selected by dir.
module bcd_mod_counter
   import bcd_cnt_pkg::*;
#(
   parameter int NDIG    = 2,
   parameter int MODULUS = 60
) (
   input  logic              clk,
   input  logic              rs_n,
   input  logic              en,
   input  logic              dir,
   input  logic              clr,
   input  logic              load,
   input  logic [4*NDIG-1:0] load_val,
   output logic [4*NDIG-1:0] bcd,
   output logic              tc,
   output logic              load_err
);

   localparam int                 W        = 4 * NDIG;
   localparam logic [4*MAX_DIG-1:0] TERM_ALL = bin2bcd(MODULUS - 1);
   localparam logic [W-1:0]       TERM     = TERM_ALL[W-1:0];

   if (NDIG < 1 || NDIG > MAX_DIG) begin : gBadNdig
      $error("bcd_mod_counter: NDIG must be 1..6");
   end
   if (MODULUS < 2 || MODULUS > 10**NDIG) begin : gBadModulus
      $error("bcd_mod_counter: MODULUS must be 2..10**NDIG");
   end

   logic          countUp, atTerm, wrapUp, wrapDown;
   logic          loadDigitsOk, loadOk;
   logic          forceZero, forceLoad;
   logic [W-1:0]  forceVal;
   logic [NDIG:0] steps;
   logic          loadErr_q, loadErr_d;

`ifdef BCD_CNT_UPDOWN_EN
   logic atZero;
   assign countUp  = dir;
   assign atZero   = (bcd == '0);
   assign wrapDown = en & ~countUp & atZero;
   assign tc       = en & (countUp ? atTerm : atZero);
`else
   // dir has no effect in the up-only build
   assign countUp  = dir | 1'b1;
   assign wrapDown = 1'b0;
   assign tc       = en & atTerm;
`endif

   assign atTerm = (bcd == TERM);
   assign wrapUp = en & countUp & atTerm;

   always_comb begin
      loadDigitsOk = 1'b1;
      for (int i = 0; i < NDIG; i++) begin
         if (load_val[4*i +: 4] > BCD_MAX) loadDigitsOk = 1'b0;
      end
   end

   // With valid nibbles, packed BCD orders the same as its decimal value
   assign loadOk = loadDigitsOk & (load_val <= TERM);

   // The chain carry-out only fires at 99..9, which is the wrap point for full-decade moduli
   assign forceZero = clr | (~load & wrapUp) | (steps[NDIG] & countUp);
   assign forceLoad = ~clr & ((load & loadOk) | (~load & wrapDown));
   assign forceVal  = load ? load_val : TERM;
   assign steps[0]  = ~clr & ~load & en;
   assign loadErr_d = ~clr & load & ~loadOk;

   for (genvar i = 0; i < NDIG; i++) begin : gDigit
      bcd_digit uDigit (
         .clk          (clk),
         .rs_n         (rs_n),
         .step_i       (steps[i]),
`ifdef BCD_CNT_UPDOWN_EN
         .dir_i        (countUp),
`endif
         .force_zero_i (forceZero),
         .force_load_i (forceLoad),
         .load_val_i   (forceVal[4*i +: 4]),
         .digit_o      (bcd[4*i +: 4]),
         .step_o       (steps[i+1])
      );
   end

   always_ff @(posedge clk or negedge rs_n) begin
      if (!rs_n) loadErr_q <= 1'b0;
      else       loadErr_q <= loadErr_d;
   end

   assign load_err = loadErr_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Testbench for bcd_mod_counter: scoreboarded mod-60 run, a mod-24 instance and a sec->min cascade.
module tb_bcd_mod_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rs_n;
   logic       one = 1'b1;
   logic       zero = 1'b0;

   logic       en, dir, clr, load;
   logic [7:0] loadVal, bcd;
   logic       tc, loadErr;

   logic       en24, load24;
   logic [7:0] loadVal24, bcd24;
   logic       tc24, err24;

   logic       enS, loadC;
   logic [7:0] loadValS, loadValM, bcdS, bcdM;
   logic       tcS, tcM, errS, errM;

   bcd_mod_counter #(.NDIG(2), .MODULUS(60)) dut (
      .clk(clk), .rs_n(rs_n), .en(en), .dir(dir), .clr(clr), .load(load),
      .load_val(loadVal), .bcd(bcd), .tc(tc), .load_err(loadErr));

   bcd_mod_counter #(.NDIG(2), .MODULUS(24)) dut24 (
      .clk(clk), .rs_n(rs_n), .en(en24), .dir(one), .clr(zero), .load(load24),
      .load_val(loadVal24), .bcd(bcd24), .tc(tc24), .load_err(err24));

   bcd_mod_counter #(.NDIG(2), .MODULUS(60)) dutSec (
      .clk(clk), .rs_n(rs_n), .en(enS), .dir(one), .clr(zero), .load(loadC),
      .load_val(loadValS), .bcd(bcdS), .tc(tcS), .load_err(errS));

   bcd_mod_counter #(.NDIG(2), .MODULUS(60)) dutMin (
      .clk(clk), .rs_n(rs_n), .en(tcS), .dir(one), .clr(zero), .load(loadC),
      .load_val(loadValM), .bcd(bcdM), .tc(tcM), .load_err(errM));

   typedef struct {
      string      tag;
      logic [7:0] bcd;
      logic       err;
   } exp_t;

   exp_t sb[$];
   int   compared   = 0;
   int   mismatched = 0;
   int   m          = 0;

   function automatic logic [7:0] toBcd(input int v);
      return 8'(((v / 10) * 16) + (v % 10));
   endfunction

   task automatic checkEq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      exp_t e;
      if (sb.size() == 0) begin
         checkEq("sbEmpty", 8'd1, 8'd0);
      end else begin
         e = sb.pop_front();
         checkEq({e.tag, "/bcd"}, bcd, e.bcd);
         checkEq({e.tag, "/err"}, {7'd0, loadErr}, {7'd0, e.err});
      end
   endtask

   // Independent decimal model of the mod-60 counter; one call is one clock edge
   task automatic applyStimulus(input string tag, input logic e, input logic d, input logic c,
                                input logic l, input logic [7:0] lv);
      exp_t x;
      logic up, expTc, ok;
      int   hi, lo;
      en = e; dir = d; clr = c; load = l; loadVal = lv;
      #1;
`ifdef BCD_CNT_UPDOWN_EN
      up = d;
`else
      up = 1'b1;
`endif
      expTc = e & (up ? (m == 59) : (m == 0));
      checkEq({tag, "/tc"}, {7'd0, tc}, {7'd0, expTc});
      hi = int'(lv[7:4]);
      lo = int'(lv[3:0]);
      ok = (hi <= 9) && (lo <= 9) && (hi * 10 + lo < 60);
      x.tag = tag;
      x.err = 1'b0;
      if (c) m = 0;
      else if (l) begin
         if (ok) m = hi * 10 + lo;
         else    x.err = 1'b1;
      end else if (e) begin
         if (up) m = (m == 59) ? 0 : m + 1;
         else    m = (m == 0) ? 59 : m - 1;
      end
      x.bcd = toBcd(m);
      sb.push_back(x);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   initial begin
      rs_n = 1'b0;
      en = 0; dir = 1; clr = 0; load = 0; loadVal = 8'h00;
      en24 = 0; load24 = 0; loadVal24 = 8'h00;
      enS = 0; loadC = 0; loadValS = 8'h00; loadValM = 8'h00;
      #12;
      checkEq("resetBcd", bcd, 8'h00);
      checkEq("resetErr", {7'd0, loadErr}, 8'h00);
      rs_n = 1'b1;
      @(posedge clk);
      #1;

      applyStimulus("load37", 0, 1, 0, 1, 8'h37);
      load = 0;
      #2;
      rs_n = 1'b0;
      #1;
      m = 0;
      checkEq("asyncRst", bcd, 8'h00);
      @(posedge clk);
      #1;
      checkEq("rstHeld", bcd, 8'h00);
      #2;
      rs_n = 1'b1;
      applyStimulus("firstAfterRst", 1, 1, 0, 0, 8'h00);
      for (int i = 0; i < 59; i++) applyStimulus("count60", 1, 1, 0, 0, 8'h00);
      for (int i = 0; i < 5; i++)  applyStimulus("hold", 0, 1, 0, 0, 8'h00);

      applyStimulus("loadOk37", 1, 1, 0, 1, 8'h37);
      applyStimulus("incAfterLoad", 1, 1, 0, 0, 8'h00);
      applyStimulus("load65Rej", 0, 1, 0, 1, 8'h65);
      applyStimulus("errClears", 0, 1, 0, 0, 8'h00);
      applyStimulus("load3ARej", 1, 1, 0, 1, 8'h3A);
      applyStimulus("incAfterRej", 1, 1, 0, 0, 8'h00);
      applyStimulus("load60Rej", 1, 1, 0, 1, 8'h60);
      applyStimulus("clrAndLoad", 1, 1, 1, 1, 8'h37);
      applyStimulus("load59OverEn", 1, 1, 0, 1, 8'h59);
      applyStimulus("wrap59", 1, 1, 0, 0, 8'h00);
      applyStimulus("load42", 0, 1, 0, 1, 8'h42);
      applyStimulus("clrOnly", 1, 1, 1, 0, 8'h00);
      applyStimulus("load10", 0, 1, 0, 1, 8'h10);
      for (int i = 0; i < 12; i++) applyStimulus("dirLow", 1, 0, 0, 0, 8'h00);
      en = 0; dir = 1;

      load24 = 1; loadVal24 = 8'h22;
      @(posedge clk); #1;
      checkEq("m24load22", bcd24, 8'h22);
      load24 = 0; en24 = 1;
      #1;
      checkEq("m24tcAt22", {7'd0, tc24}, 8'h00);
      @(posedge clk); #1;
      checkEq("m24to23", bcd24, 8'h23);
      checkEq("m24tcAt23", {7'd0, tc24}, 8'h01);
      @(posedge clk); #1;
      checkEq("m24wrap", bcd24, 8'h00);
      en24 = 0; load24 = 1; loadVal24 = 8'h09;
      @(posedge clk); #1;
      load24 = 0; en24 = 1;
      @(posedge clk); #1;
      checkEq("m24carry", bcd24, 8'h10);
      load24 = 1; en24 = 0; loadVal24 = 8'h24;
      @(posedge clk); #1;
      checkEq("m24rej24", {7'd0, err24}, 8'h01);
      checkEq("m24hold", bcd24, 8'h10);
      load24 = 0;

      loadC = 1; loadValS = 8'h59; loadValM = 8'h59;
      @(posedge clk); #1;
      checkEq("casLoadS", bcdS, 8'h59);
      checkEq("casLoadM", bcdM, 8'h59);
      checkEq("casTcIdle", {7'd0, tcS}, 8'h00);
      loadC = 0; enS = 1;
      #1;
      checkEq("casTcS", {7'd0, tcS}, 8'h01);
      checkEq("casTcM", {7'd0, tcM}, 8'h01);
      @(posedge clk); #1;
      checkEq("casWrapS", bcdS, 8'h00);
      checkEq("casWrapM", bcdM, 8'h00);
      @(posedge clk); #1;
      checkEq("casSecStep", bcdS, 8'h01);
      checkEq("casMinHold", bcdM, 8'h00);
      enS = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
